// File: rtl/mlam_pixel_pipe_if.sv
// Pixel stream handshake bundle: input pixel beat, output pixel beat and frame status.
// The master drives pixels in and accepts results; the slave is the multiplier pipe.
interface mlam_pixel_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [WIDTH-1:0]          in_coef;
  logic [1:0]                in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [31:0]               pix_count;
  logic                      frame_done;

  modport master (
    output in_valid, in_data, in_coef, in_mode, out_ready,
    input  in_ready, out_valid, out_data, pix_count, frame_done
  );

  modport slave (
    input  in_valid, in_data, in_coef, in_mode, out_ready,
    output in_ready, out_valid, out_data, pix_count, frame_done
  );
endinterface

// File: rtl/mlam_pixel_pipe.sv
// Multi-channel pixel multiplier (exact/approximate, coefficient/square), top WIDTH bits out.
// Latency: STAGES cycles from input beat to out_valid, one pixel per cycle.
// Backpressure: the whole pipe advances only when out_ready || !out_valid; in_ready mirrors that.
module mlam_pixel_pipe #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 3,
  parameter int STAGES       = 3,
  parameter int FRAME_PIXELS = 262144
) (
  input  logic            clk,
  input  logic            rst,
  mlam_pixel_pipe_if.slave bus
);
  localparam int DW = CHANNELS * WIDTH;
  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam logic [31:0] LAST_PIX = 32'(FRAME_PIXELS - 1);

  // Approximate mode drops the low x low sub-product; it is a term of a*b, so no underflow.
  function automatic logic [WIDTH-1:0] mul_top(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             approx);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    if (approx)
      p = p - PW'(a[HW-1:0]) * PW'(b[HW-1:0]);
    return p[PW-1:WIDTH];
  endfunction

  logic          en;
  logic          out_beat;
  logic [DW-1:0] prod_top;
  logic [DW-1:0] stg_dat [STAGES];
  logic [STAGES-1:0] stg_vld;
  logic [31:0]   pix_count_q;
  logic          at_last_q;

  assign en           = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = en;
  assign out_beat     = bus.out_valid && bus.out_ready;

  always_comb begin
    prod_top = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      prod_top[k*WIDTH +: WIDTH] = mul_top(bus.in_data[k*WIDTH +: WIDTH],
                                           bus.in_mode[1] ? bus.in_data[k*WIDTH +: WIDTH]
                                                          : bus.in_coef,
                                           bus.in_mode[0]);
    end
  end

  // Bubbles shift through as invalid stages; nothing moves while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      for (int s = 0; s < STAGES; s++)
        stg_dat[s] <= '0;
    end else if (en) begin
      stg_vld[0] <= bus.in_valid;
      stg_dat[0] <= prod_top;
      for (int s = 1; s < STAGES; s++) begin
        stg_vld[s] <= stg_vld[s-1];
        stg_dat[s] <= stg_dat[s-1];
      end
    end
  end

  assign bus.out_valid = stg_vld[STAGES-1];
  assign bus.out_data  = stg_dat[STAGES-1];

  // at_last_q is precomputed so frame_done needs only the live handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count_q <= '0;
      at_last_q   <= (LAST_PIX == 32'd0);
    end else if (out_beat) begin
      if (at_last_q) begin
        pix_count_q <= '0;
        at_last_q   <= (LAST_PIX == 32'd0);
      end else begin
        pix_count_q <= pix_count_q + 32'd1;
        at_last_q   <= ((pix_count_q + 32'd1) == LAST_PIX);
      end
    end
  end

  assign bus.pix_count  = pix_count_q;
  assign bus.frame_done = out_beat && at_last_q;
endmodule

// File: tb/tb_mlam_pixel_pipe.sv
// Bench for mlam_pixel_pipe (WIDTH=8, CHANNELS=3, STAGES=3, FRAME_PIXELS=4).
// Directed table vectors plus random streams scored against an arithmetic reference model.
module tb_mlam_pixel_pipe;
  localparam int F = 4;

  logic clk;
  logic rst;

  mlam_pixel_pipe_if #(.WIDTH(8), .CHANNELS(3)) bus ();

  mlam_pixel_pipe #(.WIDTH(8), .CHANNELS(3), .STAGES(3), .FRAME_PIXELS(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  coef;
    logic [1:0]  mode;
    logic [23:0] exp;
  } vec_t;

  int          checks;
  int          failures;
  int          cnt;
  int          beat_cnt;
  logic [23:0] q[$];

  function automatic logic [23:0] ref_pix(input logic [23:0] d, input logic [7:0] c,
                                          input logic [1:0] m);
    logic [23:0] r;
    int a, b, p;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      a = int'(d[k*8 +: 8]);
      b = m[1] ? a : int'(c);
      p = a * b;
      if (m[0]) p = p - (a % 16) * (b % 16);
      r[k*8 +: 8] = 8'(p / 256);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, score them, then move to just after the edge.
  task automatic step();
    logic in_beat, out_beat;
    logic [23:0] e;
    @(negedge clk);
    in_beat  = bus.in_valid && bus.in_ready;
    out_beat = bus.out_valid && bus.out_ready;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      chk("pix_count", bus.pix_count, 32'(cnt));
      chk("frame_done", 32'(bus.frame_done), 32'(out_beat && cnt == F-1));
      if (out_beat) begin
        beat_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output actual=%h required=none", bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e));
        end
        cnt = (cnt + 1) % F;
      end
      if (in_beat) q.push_back(ref_pix(bus.in_data, bus.in_coef, bus.in_mode));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic vld);
    bus.in_valid = vld;
    bus.in_data  = 24'($urandom);
    bus.in_coef  = 8'($urandom);
    bus.in_mode  = 2'($urandom_range(0, 3));
  endtask

  vec_t vecs[5];

  initial begin
    logic [23:0] hold;
    int lat, b0;
    checks = 0; failures = 0; cnt = 0; beat_cnt = 0;
    vecs[0] = '{data: 24'hFF8000, coef: 8'h00, mode: 2'b10, exp: 24'hFE4000};
    vecs[1] = '{data: 24'hFF800F, coef: 8'h00, mode: 2'b11, exp: 24'hFD4000};
    vecs[2] = '{data: 24'h101010, coef: 8'hF0, mode: 2'b01, exp: 24'h0F0F0F};
    vecs[3] = '{data: 24'h123456, coef: 8'hAB, mode: 2'b00, exp: 24'h0C2239};
    vecs[4] = '{data: 24'hFF0100, coef: 8'hFF, mode: 2'b01, exp: 24'hFD0000};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_coef = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_pix_count", bus.pix_count, 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Directed vectors: exact value and exact latency for each.
    foreach (vecs[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].data;
      bus.in_coef  = vecs[i].coef;
      bus.in_mode  = vecs[i].mode;
      lat = 0;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        step();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 3);
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp));
      step();
    end

    // Back-to-back random stream: 20 beats in 23 cycles means one per cycle.
    b0 = beat_cnt;
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("stream_beats", 32'(beat_cnt - b0), 20);
    chk("stream_drained", 32'(q.size()), 0);

    // Full pipe then a 5-cycle stall.
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      step();
    end
    drive_rand(1'b1);
    bus.out_ready = 1'b0;
    #1;
    hold = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_out_data", 32'(bus.out_data), 32'(hold));
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      drive_rand(1'b1);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("stall_drained", 32'(q.size()), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("random_drained", 32'(q.size()), 0);

    // Reset with two pixels in flight.
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_pix_count", bus.pix_count, 0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_output", 32'(bus.out_valid), 0);
      step();
    end

    // Frame of 4 pixels with a stall on the last beat.
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("frame_last_valid", 32'(bus.out_valid), 1);
    chk("frame_last_count", bus.pix_count, 3);
    for (int i = 0; i < 2; i++) begin
      chk("frame_stall_done", 32'(bus.frame_done), 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("frame_done_beat", 32'(bus.frame_done), 1);
    step();
    chk("frame_wrap_count", bus.pix_count, 0);
    chk("frame_done_after", 32'(bus.frame_done), 0);
    chk("frame_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
